outpkt_arbiter: RTL and testbench

- Shares one output-packet checksum stage between N_SRC packet sources.
- Picks a source by round-robin.
- Generates the 10-byte (5-word) packet header for that source, then streams its data words.
- Marks pkt_new on header word 0 and pkt_end on the last data word, using the downstream wr_en/full handshake.
- Sits between the per-core result/status generators and the checksum/output FIFO.

---
 rtl/outpkt_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_outpkt_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outpkt_arbiter.sv
// outpkt_arbiter: round-robin share of one checksum stage; wraps each source's data in a 5-word header.
// Optional data-underrun watchdog with 16'hDEAD padding: define OUTPKT_ARB_WATCHDOG_EN.
module outpkt_arbiter #(
  parameter int         N_SRC       = 4,
  parameter int         LEN_W       = 16,
  parameter logic [7:0] PKT_VERSION = 8'h02,
  parameter int         WD_W        = 10
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [8*N_SRC-1:0]     src_type,
  input  logic [16*N_SRC-1:0]    src_id,
  input  logic [LEN_W*N_SRC-1:0] src_len,
  input  logic [16*N_SRC-1:0]    src_din,
  input  logic [N_SRC-1:0]       src_empty,
  output logic [N_SRC-1:0]       src_rd_en,
  output logic [N_SRC-1:0]       src_grant,
  output logic [N_SRC-1:0]       src_done,
  output logic [15:0]            dout,
  output logic                   pkt_new,
  output logic                   pkt_end,
  output logic                   wr_en,
  input  logic                   full,
  output logic                   err
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, pick;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic [2:0]       hcnt_q, hcnt_d;
  logic             err_q, err_d;
  logic             pad_q, pad_d;
  logic             wd_sat;
  logic [7:0]       type_q;
  logic [15:0]      id_q;
  logic [LEN_W-1:0] len_q;
  logic [23:0]      blen;

  logic [7:0]       type_a [N_SRC];
  logic [15:0]      id_a   [N_SRC];
  logic [LEN_W-1:0] len_a  [N_SRC];
  logic [15:0]      din_a  [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign type_a[i] = src_type[8*i +: 8];
    assign id_a[i]   = src_id[16*i +: 16];
    assign len_a[i]  = src_len[LEN_W*i +: LEN_W];
    assign din_a[i]  = src_din[16*i +: 16];
  end

  // First requester strictly after the pointer, wrapping; the pointer itself is searched last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (!found && req[IDX_W'(idx)]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [23:0] byte_len(input logic [LEN_W-1:0] words);
    logic [LEN_W:0] bytes;
    bytes = {words, 1'b0};
    return {{(23-LEN_W){1'b0}}, bytes};
  endfunction

  assign pick      = rr_pick(src_req, ptr_q);
  assign blen      = byte_len(len_q);
  assign src_grant = grant_q;
  assign err       = err_q;

`ifdef OUTPKT_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      wd_cnt_q <= '0;
    else if (state_q != DATA || wr_en)
      wd_cnt_q <= '0;
    else if (!pad_q && src_empty[ptr_q] && !full && !wd_sat)
      wd_cnt_q <= wd_cnt_q + 1'b1;
  end
  assign wd_sat = &wd_cnt_q;
`else
  // Counter tied off: saturation never fires and DATA waits on src_empty forever.
  logic [WD_W-1:0] wd_cnt_q;
  assign wd_cnt_q = '0;
  assign wd_sat   = &wd_cnt_q;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_SRC-1);
      grant_q <= '0;
      wcnt_q  <= '0;
      hcnt_q  <= '0;
      err_q   <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      err_q   <= err_d;
      pad_q   <= pad_d;
    end
  end

  // Header fields are only read after a grant, so they need no reset.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && |src_req) begin
      type_q <= type_a[pick];
      id_q   <= id_a[pick];
      len_q  <= len_a[pick];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    wcnt_d    = wcnt_q;
    hcnt_d    = hcnt_q;
    err_d     = err_q;
    pad_d     = pad_q;
    wr_en     = 1'b0;
    dout      = '0;
    pkt_new   = 1'b0;
    pkt_end   = 1'b0;
    src_rd_en = '0;
    src_done  = '0;
    case (state_q)
      IDLE: begin
        if (|src_req) begin
          ptr_d          = pick;
          grant_d        = '0;
          grant_d[pick]  = 1'b1;
          hcnt_d         = '0;
          if (len_a[pick] == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        wr_en   = !full;
        pkt_new = wr_en && (hcnt_q == 3'd0);
        case (hcnt_q)
          3'd0:    dout = {PKT_VERSION, type_q};
          3'd1:    dout = 16'h0000;
          3'd2:    dout = id_q;
          3'd3:    dout = blen[15:0];
          default: dout = {8'h00, blen[23:16]};
        endcase
        if (wr_en) begin
          if (hcnt_q == 3'd4) begin
            wcnt_d  = len_q;
            state_d = DATA;
          end else begin
            hcnt_d = hcnt_q + 3'd1;
          end
        end
      end
      DATA: begin
        if (pad_q) begin
          wr_en = !full;
          dout  = 16'hDEAD;
        end else begin
          wr_en     = !full && !src_empty[ptr_q];
          dout      = din_a[ptr_q];
          src_rd_en = grant_q & {N_SRC{wr_en}};
        end
        pkt_end = wr_en && (wcnt_q == LEN_W'(1));
        if (wr_en) begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == LEN_W'(1))
            state_d = DONE;
        end else if (wd_sat && !pad_q) begin
          pad_d = 1'b1;
          err_d = 1'b1;
        end
      end
      DONE: begin
        src_done = grant_q;
        grant_d  = '0;
        pad_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_outpkt_arbiter.sv
// Bench for outpkt_arbiter: FIFO-like sources, random backpressure, and a queue-based packet/RR model.
module tb_outpkt_arbiter;
  localparam int N  = 4;
  localparam int LW = 16;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic [N-1:0]    src_req;
  logic [8*N-1:0]  src_type;
  logic [16*N-1:0] src_id;
  logic [LW*N-1:0] src_len;
  logic [16*N-1:0] src_din;
  logic [N-1:0]    src_empty;
  logic [N-1:0]    src_rd_en, src_grant, src_done;
  logic [15:0]     dout;
  logic            pkt_new, pkt_end, wr_en, full, err;

  outpkt_arbiter #(.N_SRC(N), .LEN_W(LW), .PKT_VERSION(8'h02), .WD_W(10)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .src_req(src_req), .src_type(src_type), .src_id(src_id),
    .src_len(src_len), .src_din(src_din), .src_empty(src_empty), .src_rd_en(src_rd_en),
    .src_grant(src_grant), .src_done(src_done), .dout(dout), .pkt_new(pkt_new),
    .pkt_end(pkt_end), .wr_en(wr_en), .full(full), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] dmem [N][16];
  int          dlen [N];
  int          rp   [N];
  int          mp   [N];
  int          plen [N];
  logic [7:0]  ptype [N];
  logic [15:0] pid   [N];
  logic [N-1:0] hold_empty, drop_pend, prev_grant;
  int          full_mode;
  bit          empty_rand, auto_drop;
  int          cyc_n;
  int          wr_full_cnt;

  logic [15:0] ow[$], ew[$];
  bit          onew[$], oend[$], enew[$], eend[$];
  int          o_cyc[$], grants[$], dones[$], eg[$];

  function automatic int rr_next(input logic [N-1:0] mask, input int p);
    for (int k = 1; k <= N; k++) begin
      if (mask[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    ow.delete(); onew.delete(); oend.delete(); o_cyc.delete();
    ew.delete(); enew.delete(); eend.delete();
    grants.delete(); dones.delete(); eg.delete();
    wr_full_cnt = 0;
    prev_grant  = '0;
    drop_pend   = '0;
  endtask

  task automatic load_src(input int s, input logic [7:0] t, input logic [15:0] id,
                          input int len, input int nd);
    ptype[s] = t; pid[s] = id; plen[s] = len; dlen[s] = nd; rp[s] = 0; mp[s] = 0;
    for (int k = 0; k < 16; k++) dmem[s][k] = 16'($urandom);
    src_type[s*8 +: 8]   = t;
    src_id[s*16 +: 16]   = id;
    src_len[s*LW +: LW]  = LW'(len);
  endtask

  // Expected packet: header from the protocol rules, then the source's next len words.
  task automatic model_pkt(input int s);
    int b;
    b = plen[s] * 2;
    if (plen[s] > 0) begin
      ew.push_back({8'h02, ptype[s]}); enew.push_back(1'b1); eend.push_back(1'b0);
      ew.push_back(16'h0000);          enew.push_back(1'b0); eend.push_back(1'b0);
      ew.push_back(pid[s]);            enew.push_back(1'b0); eend.push_back(1'b0);
      ew.push_back(16'(b));            enew.push_back(1'b0); eend.push_back(1'b0);
      ew.push_back(16'(b / 65536));    enew.push_back(1'b0); eend.push_back(1'b0);
      for (int k = 0; k < plen[s]; k++) begin
        ew.push_back(dmem[s][mp[s]]); enew.push_back(1'b0); eend.push_back(k == plen[s] - 1);
        mp[s]++;
      end
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, advance to next negedge.
  task automatic cyc();
    for (int i = 0; i < N; i++) begin
      src_din[i*16 +: 16] = dmem[i][rp[i] % 16];
      src_empty[i] = (rp[i] >= dlen[i]) || hold_empty[i] ||
                     (empty_rand && $urandom_range(0, 3) == 0);
    end
    case (full_mode)
      0:       full = 1'b0;
      1:       full = ~full;
      default: full = ($urandom_range(0, 99) < 35);
    endcase
    #1;
    if (wr_en) begin
      ow.push_back(dout); onew.push_back(pkt_new); oend.push_back(pkt_end); o_cyc.push_back(cyc_n);
    end
    if (wr_en && full) wr_full_cnt++;
    if (src_grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) if (src_grant[i]) grants.push_back(i);
    end
    prev_grant = src_grant;
    for (int i = 0; i < N; i++) begin
      if (src_rd_en[i]) rp[i]++;
      if (src_done[i]) begin
        dones.push_back(i);
        if (auto_drop) drop_pend[i] = 1'b1;
      end
    end
    @(negedge CLK);
    cyc_n++;
    src_req   = src_req & ~drop_pend;
    drop_pend = '0;
  endtask

  task automatic run(input int target, input int budget, output bit to);
    int b;
    b = 0;
    while (dones.size() < target && b < budget) begin
      cyc();
      b++;
    end
    to = (dones.size() < target);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    src_req = '0; full = 1'b0; src_empty = '1; src_din = '0;
    src_type = '0; src_id = '0; src_len = '0;
    hold_empty = '0; full_mode = 0; empty_rand = 1'b0; auto_drop = 1'b1;
    for (int s = 0; s < N; s++) load_src(s, 8'h00, 16'h0000, 0, 0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({src_grant, src_rd_en, src_done} !== '0) begin
      n_fail++; $display("FAIL reset_src: got %b, want 0", {src_grant, src_rd_en, src_done});
    end
    n_checks++;
    if ({wr_en, pkt_new, pkt_end, err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b, want 0000", {wr_en, pkt_new, pkt_end, err});
    end
    n_checks++;
    if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h, want 0000", dout); end
    @(negedge CLK);
  endtask

  task automatic test_single();
    bit to; int c0;
    do_reset();
    load_src(0, 8'h01, 16'h1234, 3, 3);
    model_pkt(0);
    c0 = cyc_n;
    src_req = 4'b0001;
    run(1, 60, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: got %0d dones, want 1", dones.size()); end
    n_checks++;
    if (ow.size() != ew.size()) begin
      n_fail++; $display("FAIL single_count: got %0d words, want %0d", ow.size(), ew.size());
    end
    for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
      n_checks++;
      if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
        n_fail++; $display("FAIL single_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                           k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
      end
    end
    if (o_cyc.size() == 8) begin
      n_checks++;
      if (o_cyc[0] != c0 + 1) begin
        n_fail++; $display("FAIL single_latency: got cycle %0d, want %0d", o_cyc[0], c0 + 1);
      end
      n_checks++;
      if (o_cyc[7] - o_cyc[0] != 7) begin
        n_fail++; $display("FAIL single_burst: got span %0d, want 7", o_cyc[7] - o_cyc[0]);
      end
    end
    n_checks++;
    if (dones.size() != 1 || dones[0] != 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got src %0d err %0b, want src 0 err 0",
                         (dones.size() > 0) ? dones[0] : -1, err);
    end
  endtask

  task automatic test_round_robin();
    bit to; int p, s;
    do_reset();
    for (int i = 0; i < N; i++) load_src(i, 8'h10 + 8'(i), 16'hA000 + 16'(i), 1, 2);
    auto_drop = 1'b0;
    p = N - 1;
    for (int k = 0; k < 5; k++) begin
      s = rr_next('1, p); eg.push_back(s); model_pkt(s); p = s;
    end
    src_req = '1;
    run(5, 200, to);
    src_req = '0;
    cyc(); cyc();
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rr_timeout: got %0d dones, want 5", dones.size()); end
    n_checks++;
    if (grants.size() != eg.size()) begin
      n_fail++; $display("FAIL rr_ngrants: got %0d, want %0d", grants.size(), eg.size());
    end
    for (int k = 0; k < eg.size() && k < grants.size(); k++) begin
      n_checks++;
      if (grants[k] != eg[k]) begin
        n_fail++; $display("FAIL rr_grant%0d: got %0d, want %0d", k, grants[k], eg[k]);
      end
    end
    n_checks++;
    if (ow.size() != ew.size()) begin
      n_fail++; $display("FAIL rr_count: got %0d words, want %0d", ow.size(), ew.size());
    end
    for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
      n_checks++;
      if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
        n_fail++; $display("FAIL rr_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                           k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
      end
    end
    for (int j = 1; j < 5 && 6 * j < o_cyc.size(); j++) begin
      n_checks++;
      if (o_cyc[6*j] - o_cyc[6*j-6] != 8) begin
        n_fail++; $display("FAIL rr_gap%0d: got %0d cycles, want 8", j, o_cyc[6*j] - o_cyc[6*j-6]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    load_src(2, 8'h33, 16'hBEEF, 4, 4);
    model_pkt(2);
    full_mode = 1;
    src_req = 4'b0100;
    run(1, 100, to);
    full_mode = 0;
    n_checks++;
    if (to || ow.size() != 9) begin
      n_fail++; $display("FAIL bp_count: got %0d words, want 9", ow.size());
    end
    n_checks++;
    if (wr_full_cnt != 0) begin
      n_fail++; $display("FAIL bp_wr_full: got %0d writes while full, want 0", wr_full_cnt);
    end
    for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
      n_checks++;
      if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
        n_fail++; $display("FAIL bp_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                           k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
      end
    end
  endtask

  task automatic test_underrun();
    bit to; int b, n0;
    do_reset();
    load_src(1, 8'h44, 16'h5555, 5, 5);
    model_pkt(1);
    src_req = 4'b0010;
    b = 0;
    while (ow.size() < 7 && b < 50) begin cyc(); b++; end
    n_checks++;
    if (ow.size() != 7) begin n_fail++; $display("FAIL ur_start: got %0d words, want 7", ow.size()); end
    hold_empty[1] = 1'b1;
    n0 = ow.size();
    repeat (20) cyc();
    n_checks++;
    if (ow.size() != n0) begin
      n_fail++; $display("FAIL ur_stall: got %0d words during stall, want 0", ow.size() - n0);
    end
    hold_empty = '0;
    run(1, 50, to);
    n_checks++;
    if (to || err !== 1'b0) begin n_fail++; $display("FAIL ur_end: got timeout %0b err %0b, want 0 0", to, err); end
    n_checks++;
    if (ow.size() != ew.size()) begin
      n_fail++; $display("FAIL ur_count: got %0d words, want %0d", ow.size(), ew.size());
    end
    for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
      n_checks++;
      if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
        n_fail++; $display("FAIL ur_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                           k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
      end
    end
  endtask

  task automatic test_len_zero();
    bit to; int p, s;
    logic [N-1:0] mask;
    do_reset();
    load_src(2, 8'h55, 16'h0202, 0, 0);
    load_src(3, 8'h66, 16'h0303, 2, 2);
    mask = 4'b1100; p = N - 1;
    while (mask != '0) begin
      s = rr_next(mask, p); eg.push_back(s); model_pkt(s); mask[s] = 1'b0; p = s;
    end
    src_req = 4'b1100;
    run(2, 80, to);
    n_checks++;
    if (to || dones[0] != eg[0] || dones[1] != eg[1]) begin
      n_fail++; $display("FAIL len0_done: got %0d dones, want order %0d,%0d", dones.size(), eg[0], eg[1]);
    end
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL len0_err: got %0b, want 1", err); end
    n_checks++;
    if (grants.size() != 2) begin n_fail++; $display("FAIL len0_grants: got %0d, want 2", grants.size()); end
    n_checks++;
    if (ow.size() != ew.size()) begin
      n_fail++; $display("FAIL len0_count: got %0d words, want %0d", ow.size(), ew.size());
    end
    for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
      n_checks++;
      if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
        n_fail++; $display("FAIL len0_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                           k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to; int b;
    do_reset();
    load_src(0, 8'h77, 16'h7777, 4, 4);
    src_req = 4'b0001;
    b = 0;
    while (ow.size() < 7 && b < 40) begin cyc(); b++; end
    n_checks++;
    if (ow.size() != 7) begin n_fail++; $display("FAIL rmid_start: got %0d words, want 7", ow.size()); end
    RESET_N = 1'b0;
    src_req = '0;
    #1;
    n_checks++;
    if ({src_grant, src_rd_en, src_done, wr_en, pkt_new, pkt_end, err, dout} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs: got grant %b wr %b dout %h, want all 0", src_grant, wr_en, dout);
    end
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    clear_logs();
    load_src(1, 8'h88, 16'h8888, 2, 2);
    model_pkt(1);
    src_req = 4'b0010;
    run(1, 40, to);
    n_checks++;
    if (to || grants.size() != 1 || grants[0] != 1) begin
      n_fail++; $display("FAIL rmid_grant: got %0d grants first %0d, want 1 grant to 1",
                         grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
    n_checks++;
    if (ow.size() != ew.size()) begin
      n_fail++; $display("FAIL rmid_count: got %0d words, want %0d", ow.size(), ew.size());
    end
    for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
      n_checks++;
      if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
        n_fail++; $display("FAIL rmid_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                           k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
      end
    end
  endtask

  task automatic test_random();
    bit to; int p, s, npk;
    logic [N-1:0] mask, req0;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      req0 = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        s = $urandom_range(1, 6);
        load_src(i, 8'($urandom), 16'($urandom), s, s);
      end
      mask = req0; p = N - 1; npk = 0;
      while (mask != '0) begin
        s = rr_next(mask, p); eg.push_back(s); model_pkt(s); mask[s] = 1'b0; p = s; npk++;
      end
      full_mode = 2; empty_rand = 1'b1;
      src_req = req0;
      run(npk, 800, to);
      full_mode = 0; empty_rand = 1'b0;
      n_checks++;
      if (to || wr_full_cnt != 0) begin
        n_fail++; $display("FAIL rnd%0d_run: got timeout %0b writes-while-full %0d, want 0 0", r, to, wr_full_cnt);
      end
      n_checks++;
      if (grants.size() != eg.size()) begin
        n_fail++; $display("FAIL rnd%0d_ngrants: got %0d, want %0d", r, grants.size(), eg.size());
      end
      for (int k = 0; k < eg.size() && k < grants.size(); k++) begin
        n_checks++;
        if (grants[k] != eg[k]) begin
          n_fail++; $display("FAIL rnd%0d_grant%0d: got %0d, want %0d", r, k, grants[k], eg[k]);
        end
      end
      n_checks++;
      if (ow.size() != ew.size()) begin
        n_fail++; $display("FAIL rnd%0d_count: got %0d words, want %0d", r, ow.size(), ew.size());
      end
      for (int k = 0; k < ew.size() && k < ow.size(); k++) begin
        n_checks++;
        if ({ow[k], onew[k], oend[k]} !== {ew[k], enew[k], eend[k]}) begin
          n_fail++; $display("FAIL rnd%0d_word%0d: got %h/%0b/%0b, want %h/%0b/%0b",
                             r, k, ow[k], onew[k], oend[k], ew[k], enew[k], eend[k]);
        end
      end
    end
  endtask

  initial begin
    cyc_n = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_underrun();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
